// File: rtl/addsub_rr_sched.sv
// addsub_rr_sched: round-robin scheduler sharing one registered add/subtract
// datapath between NREQ requesters. Requests are granted one at a time and
// go through IDLE (grant) -> EXEC (compute) -> RESP (hold until accepted).
// Optional build macro ADDSUB_SCHED_FLAGS_EN adds carry/borrow and signed
// overflow outputs that are registered alongside the result.
module addsub_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_op_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [W-1:0]      rsp_result_o,
`ifdef ADDSUB_SCHED_FLAGS_EN
  output logic              rsp_carry_o,
  output logic              rsp_ovf_o,
`endif
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  // Returns {signed overflow, carry/borrow, W-bit wrapped result}.
  function automatic logic [W+1:0] addsub_wrap(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic                sub);
    logic [W:0]   ext;
    logic [W-1:0] r;
    logic         ovf;
    // Zero-extended arithmetic: bit W is carry-out for add, borrow (a<b) for sub.
    ext = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r   = ext[W-1:0];
    if (sub) ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else     ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {ovf, ext};
  endfunction

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [W-1:0]          res_q, res_d;
  logic signed [W-1:0]   a_q, a_d;
  logic signed [W-1:0]   b_q, b_d;
  logic                  op_q, op_d;
  logic                  carry_q, carry_d;
  logic                  ovf_q, ovf_d;
  logic                  grant_vld;
  logic [IDW-1:0]        grant_id;
  logic [IDW-1:0]        idx;
  logic [W+1:0]          alu_w;

  assign alu_w = addsub_wrap(a_q, b_q, op_q);

  // Rotating priority search starting at rr_ptr, wrapping at NREQ-1.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
      if (!grant_vld && req_valid_i[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // One-hot accept, only offered while idle.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_vld) req_ready_o[grant_id] = 1'b1;
  end

  // Next-state, capture and result computation.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    res_d    = res_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          id_d    = grant_id;
          a_d     = $signed(req_a_i[int'(grant_id)*W +: W]);
          b_d     = $signed(req_b_i[int'(grant_id)*W +: W]);
          op_d    = req_op_i[grant_id];
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_w[W-1:0];
        carry_d = alu_w[W];
        ovf_d   = alu_w[W+1];
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rr_ptr_d = (int'(id_q) == NREQ-1) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response state; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  // Captured operands: pure data, always overwritten before use.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;

`ifdef ADDSUB_SCHED_FLAGS_EN
  assign rsp_carry_o = carry_q;
  assign rsp_ovf_o   = ovf_q;
`else
  logic unused_flags;
  assign unused_flags = carry_q ^ ovf_q;
`endif

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Self-checking bench for addsub_rr_sched with a response scoreboard.
// Build with ADDSUB_SCHED_FLAGS_EN defined to also check the flag outputs.
`timescale 1ns/1ps
module tb_addsub_rr_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*W-1:0] req_a_i;
  logic [NREQ*W-1:0] req_b_i;
  logic [NREQ-1:0]   req_op_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IDW-1:0]    rsp_id_o;
  logic [W-1:0]      rsp_result_o;
  logic              busy_o;
`ifdef ADDSUB_SCHED_FLAGS_EN
  logic              rsp_carry_o;
  logic              rsp_ovf_o;
`endif

  addsub_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_op_i     (req_op_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
`ifdef ADDSUB_SCHED_FLAGS_EN
    .rsp_carry_o  (rsp_carry_o),
    .rsp_ovf_o    (rsp_ovf_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       c;
    logic       v;
  } exp_t;

  exp_t scb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: integer arithmetic, independent of bit tricks.
  function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b,
                                 input logic op);
    exp_t e;
    int   sa, sbv, r;
    e.id = 2'(id);
    if (!op) begin
      e.res = 8'(int'(a) + int'(b));
      e.c   = (int'(a) + int'(b)) > 255;
    end else begin
      e.res = 8'(int'(a) - int'(b));
      e.c   = int'(a) < int'(b);
    end
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    r   = op ? (sa - sbv) : (sa + sbv);
    e.v = (r > 127) || (r < -128);
    return e;
  endfunction

  // Response monitor: every accepted response is popped and compared.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      total++;
      if (scb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d result=%h, expected no response", rsp_id_o, rsp_result_o);
      end else begin
        mon_e = scb.pop_front();
        if ({rsp_id_o, rsp_result_o} !== {mon_e.id, mon_e.res}) begin
          bad++;
          $display("FAIL rsp_data: got id=%0d result=%h, expected id=%0d result=%h",
                   rsp_id_o, rsp_result_o, mon_e.id, mon_e.res);
        end
`ifdef ADDSUB_SCHED_FLAGS_EN
        total++;
        if ({rsp_carry_o, rsp_ovf_o} !== {mon_e.c, mon_e.v}) begin
          bad++;
          $display("FAIL rsp_flags: got carry=%b ovf=%b, expected carry=%b ovf=%b",
                   rsp_carry_o, rsp_ovf_o, mon_e.c, mon_e.v);
        end
`endif
      end
    end
  end

  // Drive one request, wait (bounded) for its grant, push the expectation.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic op,
                       input exp_t e, output bit ok);
    req_a_i[id*8 +: 8] = a;
    req_b_i[id*8 +: 8] = b;
    req_op_i[id]       = op;
    req_valid_i[id]    = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready_o[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      scb.push_back(e);
      @(posedge clk); #1;
    end
    req_valid_i[id] = 1'b0;
  endtask

  // Bounded wait until every expected response has been seen.
  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (scb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = '0; rsp_ready_i = 1'b0;
    req_a_i = '0; req_b_i = '0; req_op_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d result=%h busy=%b, expected all 0",
               req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, busy_o);
    end
`ifdef ADDSUB_SCHED_FLAGS_EN
    total++;
    if ({rsp_carry_o, rsp_ovf_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags: got %b%b, expected 00", rsp_carry_o, rsp_ovf_o);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok;
    rsp_ready_i = 1'b1;
    req_a_i[16 +: 8] = 8'h12; req_b_i[16 +: 8] = 8'h34; req_op_i[2] = 1'b0;
    req_valid_i[2] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready_o !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready: got %b, expected 0100", req_ready_o);
    end else begin
      scb.push_back('{id: 2'd2, res: 8'h46, c: 1'b0, v: 1'b0});
      @(posedge clk); #1;
      req_valid_i[2] = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp_valid_o, busy_o, req_ready_o} !== {1'b0, 1'b1, 4'b0000}) begin
        bad++;
        $display("FAIL single_exec: got valid=%b busy=%b ready=%b, expected 0 1 0000",
                 rsp_valid_o, busy_o, req_ready_o);
      end
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL single_latency: got rsp_valid=%b two cycles after handshake, expected 1", rsp_valid_o);
      end
    end
    req_valid_i[2] = 1'b0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_drain: got %0d pending, expected 0", scb.size()); end
  endtask

  task automatic test_simultaneous();
    int order[5] = '{0, 1, 2, 3, 0};
    int cyc = 0, last = 0, g = 0, id = 0;
    bit ok;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_a_i[k*8 +: 8] = 8'(8'h10 * (k + 1));
      req_b_i[k*8 +: 8] = 8'(k + 3);
      req_op_i[k]       = k[0];
    end
    req_valid_i = 4'b1111;
    while (g < 5) begin
      @(negedge clk);
      cyc++;
      if (cyc > 40) begin
        total++; bad++;
        $display("FAIL simul_timeout: got %0d grants, expected 5", g);
        break;
      end
      if (req_ready_o != '0) begin
        id = 0;
        for (int k = 0; k < 4; k++) if (req_ready_o[k]) id = k;
        total++;
        if (req_ready_o !== 4'(1 << order[g])) begin
          bad++;
          $display("FAIL simul_order: grant %0d got ready=%b, expected id %0d", g, req_ready_o, order[g]);
        end
        if (g > 0) begin
          total++;
          if (cyc - last !== 3) begin
            bad++;
            $display("FAIL simul_interval: got %0d cycles, expected 3", cyc - last);
          end
        end
        last = cyc;
        scb.push_back(model(id, req_a_i[id*8 +: 8], req_b_i[id*8 +: 8], req_op_i[id]));
        @(posedge clk); #1;
        if (id == 0 && g == 0) begin
          req_a_i[7:0] = 8'hF0; req_b_i[7:0] = 8'h20; req_op_i[0] = 1'b1;
        end else begin
          req_valid_i[id] = 1'b0;
        end
        g++;
      end
    end
    req_valid_i = '0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL simul_drain: got %0d pending, expected 0", scb.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    rsp_ready_i = 1'b0;
    issue(1, 8'h05, 8'h07, 1'b1, '{id: 2'd1, res: 8'hFE, c: 1'b1, v: 1'b0}, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_grant: got no grant, expected grant to 1"); end
    req_a_i[7:0] = 8'h33; req_b_i[7:0] = 8'h11; req_op_i[0] = 1'b0;
    req_valid_i[0] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid_o, rsp_id_o, rsp_result_o, req_ready_o} !== {1'b1, 2'd1, 8'hFE, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d got valid=%b id=%0d result=%h ready=%b, expected 1 1 fe 0000",
                 n, rsp_valid_o, rsp_id_o, rsp_result_o, req_ready_o);
      end
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_retire: got rsp_valid=%b after accept, expected 0", rsp_valid_o);
    end
    issue(0, 8'h33, 8'h11, 1'b0, model(0, 8'h33, 8'h11, 1'b0), ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_next_grant: got no grant, expected grant to 0"); end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_drain: got %0d pending, expected 0", scb.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    rsp_ready_i = 1'b1;
    issue(0, 8'hFF, 8'h01, 1'b0, '{id: 2'd0, res: 8'h00, c: 1'b1, v: 1'b0}, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_add_grant: got no grant, expected grant"); end
    issue(1, 8'h00, 8'h01, 1'b1, '{id: 2'd1, res: 8'hFF, c: 1'b1, v: 1'b0}, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_sub_grant: got no grant, expected grant"); end
    issue(2, 8'h7F, 8'h01, 1'b0, '{id: 2'd2, res: 8'h80, c: 1'b0, v: 1'b1}, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_ovf_grant: got no grant, expected grant"); end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_drain: got %0d pending, expected 0", scb.size()); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    rsp_ready_i = 1'b1;
    issue(2, 8'h11, 8'h22, 1'b0, model(2, 8'h11, 8'h22, 1'b0), ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_grant: got no grant, expected grant"); end
    rst_n = 1'b0;
    #1;
    scb.delete();
    total++;
    if ({req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got ready=%b valid=%b id=%0d result=%h busy=%b, expected all 0",
               req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, busy_o);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL midrst_no_rsp: got rsp_valid=%b, expected 0", rsp_valid_o);
      end
    end
    @(posedge clk); #1;
    req_a_i[7:0]   = 8'h21; req_b_i[7:0]   = 8'h01; req_op_i[0] = 1'b1;
    req_a_i[31:24] = 8'h80; req_b_i[31:24] = 8'h80; req_op_i[3] = 1'b0;
    req_valid_i = 4'b1001;
    @(negedge clk);
    total++;
    if (req_ready_o !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_ptr: got ready=%b, expected 0001", req_ready_o);
    end else begin
      scb.push_back('{id: 2'd0, res: 8'h20, c: 1'b0, v: 1'b0});
      @(posedge clk); #1;
      req_valid_i[0] = 1'b0;
    end
    req_valid_i[0] = 1'b0;
    issue(3, 8'h80, 8'h80, 1'b0, '{id: 2'd3, res: 8'h00, c: 1'b1, v: 1'b1}, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_grant3: got no grant, expected grant to 3"); end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_drain: got %0d pending, expected 0", scb.size()); end
  endtask

  task automatic test_fairness();
    int  n;
    bit  ok;
    rsp_ready_i = 1'b1;
    req_a_i[7:0]   = 8'h01; req_b_i[7:0]   = 8'h02; req_op_i[0] = 1'b0;
    req_a_i[31:24] = 8'h40; req_b_i[31:24] = 8'h40; req_op_i[3] = 1'b0;
    req_valid_i[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready_o != '0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || req_ready_o !== 4'b0001) begin
      bad++;
      $display("FAIL fair_first: got ready=%b, expected 0001", req_ready_o);
    end
    scb.push_back(model(0, 8'h01, 8'h02, 1'b0));
    @(posedge clk); #1;
    req_valid_i[3] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready_o == '0 && n < 20);
    total++;
    if ({req_ready_o, 8'(n)} !== {4'b1000, 8'd3}) begin
      bad++;
      $display("FAIL fair_req3: got ready=%b after %0d cycles, expected 1000 after 3", req_ready_o, n);
    end
    scb.push_back('{id: 2'd3, res: 8'h80, c: 1'b0, v: 1'b1});
    @(posedge clk); #1;
    req_valid_i[3] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready_o == '0 && n < 20);
    total++;
    if (req_ready_o !== 4'b0001) begin
      bad++;
      $display("FAIL fair_back_to_0: got ready=%b, expected 0001", req_ready_o);
    end
    scb.push_back(model(0, 8'h01, 8'h02, 1'b0));
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fair_drain: got %0d pending, expected 0", scb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_rr_sched.md
# addsub_rr_sched

Round-robin scheduler that shares one registered 8-bit add/subtract datapath between several requesters. Each requester presents operands and an opcode on a valid/ready handshake. The block grants one request at a time, sequences it through the datapath, and returns the result with the requester ID on a single valid/ready response channel. It sits between the client front-ends and the arithmetic unit, so only one adder/subtractor is needed in the design.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `W`, default 8: operand and result width.
- `IDW`, default 2: requester ID width; must equal clog2(NREQ).
- `clk`, input, 1: single clock, all state on rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid_i`, input, NREQ: request valid per requester.
- `req_ready_o`, output, NREQ: one-hot grant/accept per requester.
- `req_a_i`, input, NREQ*W: operand A, requester k at bits [k*W +: W].
- `req_b_i`, input, NREQ*W: operand B, same packing as `req_a_i`.
- `req_op_i`, input, NREQ: 0 = add, 1 = subtract (A−B).
- `rsp_valid_o`, output, 1: result valid.
- `rsp_ready_i`, input, 1: consumer accepts result.
- `rsp_id_o`, output, IDW: index of the requester that owns the result.
- `rsp_result_o`, output, W: result, modulo 2^W.
- `busy_o`, output, 1: high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the first requester with `req_valid_i` high, searching from `rr_ptr` upward and wrapping at NREQ−1.
  - `req_ready_o` is one-hot on the granted bit. It is combinational from `req_valid_i` and `rr_ptr`, and all-zero when no request is valid.
  - Handshake completes when valid and ready are both high. On completion, capture A, B, op and the ID, then go to EXEC.
- **EXEC** (one cycle)
  - Register the result: A+B or A−B, truncated to W bits, two's-complement wrap.
  - Go to RESP.
- **RESP**
  - `rsp_valid_o` = 1; `rsp_id_o` and `rsp_result_o` hold steady until `rsp_ready_i` = 1.
  - On acceptance: `rr_ptr` ← (granted ID + 1) mod NREQ, then go to IDLE.
- `req_ready_o` is all-zero in EXEC and RESP. Requesters must hold valid and operands stable until accepted.
- A requester deasserting valid before it is granted is legal; it is simply skipped.
- A requester that was just served has lowest priority on the next arbitration, so no requester starves.

## Timing
- Reset values:
  - `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_id_o` = 0, `rsp_result_o` = 0, `busy_o` = 0.
  - `rr_ptr` = 0; flag outputs = 0.
- Latency from the request handshake edge:
  - `rsp_valid_o` rises 2 cycles later (EXEC, then RESP).
  - Minimum issue interval is 3 cycles per operation when `rsp_ready_i` is held high.
- `rsp_ready_i` asserted on the first RESP cycle:
  - Response retires that edge.
  - Next grant is possible in the following IDLE cycle.
- Backpressure: RESP holds indefinitely with all outputs stable; there is no timeout.
- `rsp_ready_i` high outside RESP is ignored.
- Simultaneous valids: exactly one grant per IDLE cycle; the others wait.
- Reset asserted mid-operation:
  - In-flight request and result are discarded; no response is issued.
  - FSM returns to IDLE and `rr_ptr` returns to 0.
- Wrap cases:
  - 0xFF + 0x01 → 0x00.
  - 0x00 − 0x01 → 0xFF.

## Configuration
- `ADDSUB_SCHED_FLAGS_EN` defined:
  - Adds outputs `rsp_carry_o` (1 bit) and `rsp_ovf_o` (1 bit), registered with the result in EXEC and held through RESP.
  - `rsp_carry_o`: add = carry-out; subtract = borrow (A < B unsigned).
  - `rsp_ovf_o`: signed two's-complement overflow.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Single request.** Reset; requester 2 requests A=0x12, B=0x34, op=0.
  - `req_ready_o` = 0b0100 in the same cycle.
  - `rsp_valid_o` rises 2 cycles after the handshake with id=2, result=0x46.
- **Simultaneous requests.** All 4 valid from reset, `rsp_ready_i` = 1.
  - Grant order 0, 1, 2, 3, 0.
  - Successive grants 3 cycles apart.
- **Backpressure.** Requester 1 sends 0x05 − 0x07; hold `rsp_ready_i` = 0 for 5 cycles.
  - result=0xFE and id=1 stable throughout; `req_ready_o` = 0 throughout.
  - Retires on the cycle `rsp_ready_i` rises.
- **Wrap.** 0xFF + 0x01 → 0x00; 0x00 − 0x01 → 0xFF.
  - With flags enabled: carry=1/ovf=0 and borrow=1/ovf=0 respectively.
  - With flags enabled: 0x7F + 0x01 → 0x80, ovf=1.
- **Reset mid-operation.** Assert `rst_n` = 0 during EXEC.
  - All outputs 0 immediately; no response afterwards.
  - Next grant after reset starts from requester 0.
- **Fairness.** Requester 0 valid continuously, requester 3 valid once.
  - Requester 3 is granted at the first IDLE after requester 0's response retires.
